// File: rtl/frogg_traffic_ctrl.sv
// Frogg traffic, collision and game-flow controller.
// Moves N car lanes in alternating directions with level-dependent speed.
// Detects frog/car collisions on frame ticks and tracks lives and level.
// Produces a registered car-draw flag for the current tile of the 40x30 grid.
module frogg_traffic_ctrl #(
    parameter int c_NUM_LANES    = 4,
    parameter int c_GAME_WIDTH   = 40,
    parameter int c_GAME_HEIGHT  = 30,
    parameter int c_LANE_ROW0    = 24,
    parameter int c_LANE_SPACING = 4,
    parameter int c_CAR_WIDTH    = 2,
    parameter int c_LIVES        = 3,
    parameter int c_MAX_LEVEL    = 9,
    parameter int c_BASE_PERIOD  = 12
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Col_Count_Div,
    input  logic [5:0] i_Row_Count_Div,
    input  logic [5:0] i_Frog_X,
    input  logic [5:0] i_Frog_Y,
    output logic       o_Draw_Car,
    output logic       o_Game_Active,
    output logic       o_Frog_Reset,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Game_Over
);

    // The widest lane period is c_BASE_PERIOD + 2*(c_NUM_LANES-1); 8 bits covers
    // every legal parameter combination with plenty of margin.
    localparam int CNT_W = 8;

    localparam logic [5:0] GW_M1     = 6'(c_GAME_WIDTH - 1);
    localparam logic [6:0] GW_7      = 7'(c_GAME_WIDTH);
    localparam logic [6:0] CAR_W_7   = 7'(c_CAR_WIDTH);
    localparam logic [5:0] HEIGHT_6  = 6'(c_GAME_HEIGHT);
    localparam logic [2:0] LIVES_3   = 3'(c_LIVES);
    localparam logic [3:0] MAX_LVL_4 = 4'(c_MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    // Tile row occupied by lane k.
    function automatic logic [5:0] lane_row(input int k);
        return 6'(c_LANE_ROW0 - k * c_LANE_SPACING);
    endfunction

    // Starting column of lane k: lanes spread evenly across the width.
    function automatic logic [5:0] init_x(input int k);
        return 6'((k * (c_GAME_WIDTH / c_NUM_LANES)) % c_GAME_WIDTH);
    endfunction

    // True when column px lies inside the car span starting at cx, with the
    // span wrapping from the last column back to column 0.
    function automatic logic in_span(input logic [5:0] px, input logic [5:0] cx);
        logic [6:0] diff;
        logic [6:0] wrapped;
        diff = {1'b0, px} - {1'b0, cx};
        if (diff[6]) begin
            wrapped = diff + GW_7;
        end else begin
            wrapped = diff;
        end
        return (wrapped < CAR_W_7);
    endfunction

    // Frames per step of lane k at the given level, never below one.
    function automatic logic [CNT_W-1:0] lane_period(input int k, input logic [3:0] level);
        int p;
        p = c_BASE_PERIOD + 2 * k - 2 * int'(level);
        p = (p < 1) ? 1 : p;
        return CNT_W'(p);
    endfunction

    // One-tile move: even lanes travel right, odd lanes travel left, both wrap.
    function automatic logic [5:0] step_x(input int k, input logic [5:0] x);
        logic [5:0] nx;
        if ((k % 2) == 0) begin
            nx = (x >= GW_M1) ? 6'd0 : x + 6'd1;
        end else begin
            nx = (x == 6'd0) ? GW_M1 : x - 6'd1;
        end
        return nx;
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic [5:0]       car_x_q [c_NUM_LANES];
    logic [5:0]       car_x_d [c_NUM_LANES];
    logic [CNT_W-1:0] cnt_q   [c_NUM_LANES];
    logic [CNT_W-1:0] cnt_d   [c_NUM_LANES];
    logic             frog_reset_q;
    logic             active_q;
    logic             over_q;
    logic             draw_q, draw_d;
    logic             collide_s;

    // Frog/car overlap against the current (pre-move) car positions.
    always_comb begin
        collide_s = 1'b0;
        for (int k = 0; k < c_NUM_LANES; k++) begin
            if ((i_Frog_Y == lane_row(k)) && in_span(i_Frog_X, car_x_q[k])) begin
                collide_s = 1'b1;
            end else begin
                collide_s = collide_s;
            end
        end
    end

    // Car coverage of the tile currently being scanned, in every state.
    always_comb begin
        draw_d = 1'b0;
        for (int k = 0; k < c_NUM_LANES; k++) begin
            if ((i_Row_Count_Div == lane_row(k)) &&
                (i_Row_Count_Div < HEIGHT_6) &&
                in_span(i_Col_Count_Div, car_x_q[k])) begin
                draw_d = 1'b1;
            end else begin
                draw_d = draw_d;
            end
        end
    end

    // Game-flow next state, lives/level updates and lane motion.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        car_x_d = car_x_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_Game_Start) begin
                    state_d = ST_RUNNING;
                    lives_d = LIVES_3;
                    level_d = 4'd0;
                    for (int k = 0; k < c_NUM_LANES; k++) begin
                        car_x_d[k] = init_x(k);
                        cnt_d[k]   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUNNING: begin
                if (!i_Frame_Tick) begin
                    state_d = ST_RUNNING;
                end else if (collide_s) begin
                    // A hit takes priority over reaching the top row.
                    state_d = ST_HIT;
                end else if (i_Frog_Y == 6'd0) begin
                    state_d = ST_LEVEL_UP;
                end else begin
                    for (int k = 0; k < c_NUM_LANES; k++) begin
                        // >= lets a lane whose period just shrank step at once.
                        if (cnt_q[k] >= (lane_period(k, level_q) - CNT_W'(1))) begin
                            cnt_d[k]   = {CNT_W{1'b0}};
                            car_x_d[k] = step_x(k, car_x_q[k]);
                        end else begin
                            cnt_d[k]   = cnt_q[k] + CNT_W'(1);
                        end
                    end
                end
            end
            ST_HIT: begin
                lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                if (lives_q <= 3'd1) begin
                    state_d = ST_GAME_OVER;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_LEVEL_UP: begin
                if (level_q < MAX_LVL_4) begin
                    level_d = level_q + 4'd1;
                end else begin
                    level_d = level_q;
                end
                state_d = ST_RUNNING;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Game state, lanes and status outputs; outputs are decoded from the next state.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            lives_q      <= LIVES_3;
            level_q      <= 4'd0;
            frog_reset_q <= 1'b0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
            for (int k = 0; k < c_NUM_LANES; k++) begin
                car_x_q[k] <= init_x(k);
                cnt_q[k]   <= {CNT_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            frog_reset_q <= (state_d == ST_HIT) || (state_d == ST_LEVEL_UP);
            active_q     <= (state_d == ST_RUNNING);
            over_q       <= (state_d == ST_GAME_OVER);
            for (int k = 0; k < c_NUM_LANES; k++) begin
                car_x_q[k] <= car_x_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Draw flag, one cycle behind the tile counters to line up with the syncs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            draw_q <= 1'b0;
        end else begin
            draw_q <= draw_d;
        end
    end

    assign o_Draw_Car    = draw_q;
    assign o_Game_Active = active_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Game_Over   = over_q;

endmodule

// File: tb/tb_frogg_traffic_ctrl.sv
// Directed, table-driven bench for frogg_traffic_ctrl.
module tb_frogg_traffic_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       game_start;
    logic [5:0] col;
    logic [5:0] row;
    logic [5:0] frog_x;
    logic [5:0] frog_y;
    logic       draw_car;
    logic       game_active;
    logic       frog_reset;
    logic [2:0] lives;
    logic [3:0] level;
    logic       game_over;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [5:0] col;
        logic [5:0] row;
        logic       exp_draw;
    } draw_vec_t;

    localparam int N_VEC = 15;
    draw_vec_t vecs [N_VEC];

    frogg_traffic_ctrl dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Frame_Tick    (frame_tick),
        .i_Game_Start    (game_start),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .i_Frog_X        (frog_x),
        .i_Frog_Y        (frog_y),
        .o_Draw_Car      (draw_car),
        .o_Game_Active   (game_active),
        .o_Frog_Reset    (frog_reset),
        .o_Lives         (lives),
        .o_Level         (level),
        .o_Game_Over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Present a tile and return the registered draw flag one cycle later.
    task automatic probe(input logic [5:0] c, input logic [5:0] r, output logic d);
        col = c;
        row = r;
        @(posedge clk);
        #1;
        d = draw_car;
    endtask

    task automatic probe_check(input string name, input logic [5:0] c, input logic [5:0] r,
                               input logic exp);
        logic d;
        probe(c, r, d);
        check($sformatf("%s_%0d_%0d", name, c, r), {7'd0, d}, {7'd0, exp});
    endtask

    // n frame ticks, each followed by one idle cycle for HIT/LEVEL_UP to finish.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_draw_table(input string tag);
        for (int i = 0; i < N_VEC; i++) begin
            probe_check(tag, vecs[i].col, vecs[i].row, vecs[i].exp_draw);
        end
    endtask

    initial begin
        // Initial car spans: lane0 X0 row24, lane1 X10 row20, lane2 X20 row16, lane3 X30 row12.
        vecs[0]  = '{6'd0,  6'd24, 1'b1};
        vecs[1]  = '{6'd1,  6'd24, 1'b1};
        vecs[2]  = '{6'd2,  6'd24, 1'b0};
        vecs[3]  = '{6'd39, 6'd24, 1'b0};
        vecs[4]  = '{6'd10, 6'd20, 1'b1};
        vecs[5]  = '{6'd11, 6'd20, 1'b1};
        vecs[6]  = '{6'd9,  6'd20, 1'b0};
        vecs[7]  = '{6'd20, 6'd16, 1'b1};
        vecs[8]  = '{6'd22, 6'd16, 1'b0};
        vecs[9]  = '{6'd30, 6'd12, 1'b1};
        vecs[10] = '{6'd31, 6'd12, 1'b1};
        vecs[11] = '{6'd32, 6'd12, 1'b0};
        vecs[12] = '{6'd0,  6'd23, 1'b0};
        vecs[13] = '{6'd30, 6'd24, 1'b0};
        vecs[14] = '{6'd10, 6'd16, 1'b0};

        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        game_start = 1'b0;
        col        = 6'd5;
        row        = 6'd5;
        frog_x     = 6'd20;
        frog_y     = 6'd29;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_active", {7'd0, game_active}, 8'd0);
        check("rst_over",   {7'd0, game_over},   8'd0);
        check("rst_freset", {7'd0, frog_reset},  8'd0);
        check("rst_lives",  {5'd0, lives},       8'd3);
        check("rst_level",  {4'd0, level},       8'd0);
        check("rst_draw",   {7'd0, draw_car},    8'd0);

        // Frozen cars are drawn in IDLE at their initial positions.
        run_draw_table("idle_draw");

        // Start and basic lane motion.
        game_start = 1'b1;
        @(posedge clk);
        #1;
        game_start = 1'b0;
        check("start_active", {7'd0, game_active}, 8'd1);
        check("start_lives",  {5'd0, lives},       8'd3);
        tick_n(11);
        probe_check("t11_lane0", 6'd0, 6'd24, 1'b1);
        probe_check("t11_lane0", 6'd2, 6'd24, 1'b0);
        tick_n(1);
        probe_check("t12_lane0", 6'd2, 6'd24, 1'b1);
        probe_check("t12_lane0", 6'd0, 6'd24, 1'b0);
        probe_check("t12_lane1", 6'd9, 6'd20, 1'b0);
        tick_n(1);
        probe_check("t13_lane1", 6'd9, 6'd20, 1'b0);
        tick_n(1);
        probe_check("t14_lane1", 6'd9,  6'd20, 1'b1);
        probe_check("t14_lane1", 6'd11, 6'd20, 1'b0);
        check("t14_active", {7'd0, game_active}, 8'd1);
        check("t14_lives",  {5'd0, lives},       8'd3);

        // Level up: frog on row 0, one-cycle frog reset pulse.
        frog_x = 6'd5;
        frog_y = 6'd0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check("lvl_pulse_hi", {7'd0, frog_reset}, 8'd1);
        @(posedge clk);
        #1;
        check("lvl_pulse_lo", {7'd0, frog_reset},  8'd0);
        check("lvl_level1",   {4'd0, level},       8'd1);
        check("lvl_active",   {7'd0, game_active}, 8'd1);
        tick_n(5);
        check("lvl_level6",   {4'd0, level},       8'd6);
        frog_x = 6'd20;
        frog_y = 6'd29;

        // At level 6 lane 0 period clamps to 1: step every tick (X 1 -> 2).
        tick_n(1);
        probe_check("fast_lane0", 6'd1, 6'd24, 1'b0);
        probe_check("fast_lane0", 6'd2, 6'd24, 1'b1);
        probe_check("fast_lane0", 6'd3, 6'd24, 1'b1);
        tick_n(37);
        probe_check("wrap_lane0", 6'd39, 6'd24, 1'b1);
        probe_check("wrap_lane0", 6'd0,  6'd24, 1'b1);
        probe_check("wrap_lane0", 6'd1,  6'd24, 1'b0);
        probe_check("wrap_lane0", 6'd38, 6'd24, 1'b0);

        // Collision through the wrap: car at 39 covers column 0.
        frog_x = 6'd0;
        frog_y = 6'd24;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        frog_x = 6'd20;
        frog_y = 6'd29;
        check("hit_pulse_hi", {7'd0, frog_reset},  8'd1);
        check("hit_inactive", {7'd0, game_active}, 8'd0);
        @(posedge clk);
        #1;
        check("hit_pulse_lo", {7'd0, frog_reset},  8'd0);
        check("hit_lives2",   {5'd0, lives},       8'd2);
        check("hit_running",  {7'd0, game_active}, 8'd1);
        check("hit_level",    {4'd0, level},       8'd6);

        // Top row at a car column is not a collision; level saturates at 9.
        frog_x = 6'd39;
        frog_y = 6'd0;
        tick_n(1);
        check("top_level7", {4'd0, level}, 8'd7);
        check("top_lives",  {5'd0, lives}, 8'd2);
        tick_n(3);
        check("lvl_sat9",   {4'd0, level}, 8'd9);

        // Two more hits on lane 0 (frozen at 39) end the game.
        frog_x = 6'd39;
        frog_y = 6'd24;
        tick_n(1);
        check("hit2_lives1", {5'd0, lives}, 8'd1);
        check("hit2_over",   {7'd0, game_over}, 8'd0);
        tick_n(1);
        frog_x = 6'd20;
        frog_y = 6'd29;
        check("go_lives0",  {5'd0, lives},       8'd0);
        check("go_over",    {7'd0, game_over},   8'd1);
        check("go_active",  {7'd0, game_active}, 8'd0);
        tick_n(50);
        probe_check("go_frozen", 6'd39, 6'd24, 1'b1);
        probe_check("go_frozen", 6'd0,  6'd24, 1'b1);
        probe_check("go_frozen", 6'd1,  6'd24, 1'b0);
        check("go_lives_hold", {5'd0, lives},     8'd0);
        check("go_over_hold",  {7'd0, game_over}, 8'd1);

        // Restart from GAME_OVER reloads lives, level and positions.
        game_start = 1'b1;
        @(posedge clk);
        #1;
        game_start = 1'b0;
        check("re_active", {7'd0, game_active}, 8'd1);
        check("re_over",   {7'd0, game_over},   8'd0);
        check("re_lives",  {5'd0, lives},       8'd3);
        check("re_level",  {4'd0, level},       8'd0);
        run_draw_table("re_draw");

        // Mid-game reset between clock edges.
        tick_n(12);
        frog_x = 6'd5;
        frog_y = 6'd0;
        tick_n(1);
        frog_x = 6'd20;
        frog_y = 6'd29;
        check("pre_rst_level", {4'd0, level}, 8'd1);
        probe_check("pre_rst_draw", 6'd1, 6'd24, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_draw",   {7'd0, draw_car},    8'd0);
        check("mid_rst_active", {7'd0, game_active}, 8'd0);
        check("mid_rst_freset", {7'd0, frog_reset},  8'd0);
        check("mid_rst_over",   {7'd0, game_over},   8'd0);
        check("mid_rst_lives",  {5'd0, lives},       8'd3);
        check("mid_rst_level",  {4'd0, level},       8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Draw latency: one cycle behind the tile counters.
        col = 6'd5;
        row = 6'd5;
        @(posedge clk);
        #1;
        col = 6'd0;
        row = 6'd24;
        #4;
        check("lat_before", {7'd0, draw_car}, 8'd0);
        @(posedge clk);
        #1;
        check("lat_after", {7'd0, draw_car}, 8'd1);
        col = 6'd5;
        row = 6'd5;
        #4;
        check("lat_hold", {7'd0, draw_car}, 8'd1);
        @(posedge clk);
        #1;
        check("lat_clear", {7'd0, draw_car}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
